// File: rtl/card_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : card_pkg
//  Description : Shared constants for the card dealer and card decode logic:
//                deck geometry, blackjack point values and the dealer FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package card_pkg;

  // Deck geometry
  localparam int DECK_SIZE      = 52;
  localparam int CARD_W         = 6;
  localparam int RANKS_PER_SUIT = 13;

  // Blackjack point values
  localparam int ACE_POINTS     = 11;
  localparam int FACE_POINTS    = 10;

  // Dealer FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_EMPTY = 2'd3;

endpackage
`default_nettype wire

// File: rtl/card_decode.sv
`default_nettype none
// ============================================================================
//  Module      : card_decode
//  Description : Combinational card decoder. Splits a card code (0..51) into
//                suit (code / 13), rank (code % 13 + 1, Ace=1..King=13) and
//                blackjack points (Ace=11, 2..10 face value, J/Q/K=10).
//                Shared between the dealer and the hand-scoring logic.
//  Ports       : card   in  CARD_W  card code
//                rank   out 4       1=Ace .. 13=King
//                points out 4       blackjack points
//                suit   out 2       0..3
//  Revision    : 1.0 - initial release
// ============================================================================
module card_decode
  import card_pkg::*;
(
  input  logic [CARD_W-1:0] card,
  output logic [3:0]        rank,
  output logic [3:0]        points,
  output logic [1:0]        suit
);

  // First card code of the decoded suit; subtracting it yields rank-1.
  logic [CARD_W-1:0] suit_base;

  // Division by 13 is replaced by three threshold compares.
  always_comb begin
    suit      = 2'd3;
    suit_base = CARD_W'(3 * RANKS_PER_SUIT);
    if (card < CARD_W'(RANKS_PER_SUIT)) begin
      suit      = 2'd0;
      suit_base = '0;
    end else if (card < CARD_W'(2 * RANKS_PER_SUIT)) begin
      suit      = 2'd1;
      suit_base = CARD_W'(RANKS_PER_SUIT);
    end else if (card < CARD_W'(3 * RANKS_PER_SUIT)) begin
      suit      = 2'd2;
      suit_base = CARD_W'(2 * RANKS_PER_SUIT);
    end

    rank = 4'(card - suit_base + CARD_W'(1));

    if (rank == 4'd1) begin
      points = 4'(ACE_POINTS);
    end else if (rank > 4'd10) begin
      points = 4'(FACE_POINTS);
    end else begin
      points = rank;
    end
  end

endmodule
`default_nettype wire

// File: rtl/card_dealer.sv
`default_nettype none
// ============================================================================
//  Module      : card_dealer
//  Description : Downstream stage of the deck shuffler. On start it requests
//                a shuffle, captures the card stream into a local deck
//                buffer, then serves one card per deal request, decoded into
//                rank and blackjack points. Tracks remaining cards and flags
//                a low deck so the controller can trigger a reshuffle.
//  Ports       : clk          in   system clock, rising edge
//                rst          in   asynchronous reset, active low
//                start        in   pulse: begin a new shuffle/load
//                card_valid   in   strobe per card from the shuffler
//                card_in      in   card code, valid with card_valid
//                deal_req     in   request one card (may be held)
//                shuffle_req  out  shuffler request, high while loading
//                deck_ready   out  deck loaded and not empty
//                deal_valid   out  strobe, dealt card outputs valid
//                deal_card    out  dealt card code
//                deal_rank    out  1=Ace .. 13=King
//                deal_points  out  Ace=11, 2..10, J/Q/K=10
//                cards_left   out  undealt cards remaining
//                low_deck     out  cards_left <= LOW_THRESH while ready
//                load_err     out  sticky invalid/duplicate card flag
//                empty_err    out  pulse: deal request with no cards left
//  Options     : DEAL_DUP_CHECK_EN - when defined, duplicate cards within a
//                load are discarded and flagged; the load completes only
//                after DECK_SIZE unique cards.
//  Revision    : 1.0 - initial release
// ============================================================================
module card_dealer
  import card_pkg::*;
#(
  parameter int LOW_THRESH = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              card_valid,
  input  logic [CARD_W-1:0] card_in,
  input  logic              deal_req,
  output logic              shuffle_req,
  output logic              deck_ready,
  output logic              deal_valid,
  output logic [CARD_W-1:0] deal_card,
  output logic [3:0]        deal_rank,
  output logic [3:0]        deal_points,
  output logic [5:0]        cards_left,
  output logic              low_deck,
  output logic              load_err,
  output logic              empty_err
);

  localparam int PTR_W = $clog2(DECK_SIZE);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,       state_d;
  logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
  logic [5:0]       cards_left_q,  cards_left_d;
  logic             deal_valid_q,  deal_valid_d;
  logic [1:0]       deal_suit_q,   deal_suit_d;
  logic [3:0]       deal_rank_q,   deal_rank_d;
  logic [3:0]       deal_points_q, deal_points_d;
  logic             load_err_q,    load_err_d;
  logic             empty_err_q,   empty_err_d;
`ifdef DEAL_DUP_CHECK_EN
  logic [DECK_SIZE-1:0] seen_q,    seen_d;
`endif

  // Deck buffer; contents are don't-care until written, so it has no reset.
  logic [CARD_W-1:0] deck_mem [DECK_SIZE];
  logic              mem_we;

  logic              card_ok;
  logic              start_load;
  logic [3:0]        dec_rank;
  logic [3:0]        dec_points;
  logic [1:0]        dec_suit;

  assign card_ok = (card_in < CARD_W'(DECK_SIZE));

  // Decode the card at the head of the deck so it is ready when dealt.
  card_decode u_card_decode (
    .card   (deck_mem[rd_ptr_q]),
    .rank   (dec_rank),
    .points (dec_points),
    .suit   (dec_suit)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cards_left_d  = cards_left_q;
    deal_valid_d  = 1'b0;
    deal_suit_d   = deal_suit_q;
    deal_rank_d   = deal_rank_q;
    deal_points_d = deal_points_q;
    load_err_d    = load_err_q;
    empty_err_d   = 1'b0;
    mem_we        = 1'b0;
    start_load    = 1'b0;
`ifdef DEAL_DUP_CHECK_EN
    seen_d        = seen_q;
`endif

    case (state_q)
      ST_IDLE: begin
        start_load = start;
      end

      // start and deal_req are deliberately not looked at while loading.
      ST_LOAD: begin
        if (card_valid) begin
          if (!card_ok) begin
            load_err_d = 1'b1;
`ifdef DEAL_DUP_CHECK_EN
          end else if (seen_q[card_in]) begin
            load_err_d = 1'b1;
`endif
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
`ifdef DEAL_DUP_CHECK_EN
            seen_d[card_in] = 1'b1;
`endif
            if (wr_ptr_q == PTR_W'(DECK_SIZE - 1)) begin
              state_d      = ST_READY;
              wr_ptr_d     = '0;
              rd_ptr_d     = '0;
              cards_left_d = 6'(DECK_SIZE);
            end
          end
        end
      end

      // start has priority over deal_req: a reshuffle drops the remaining
      // cards without dealing one.
      ST_READY: begin
        if (start) begin
          start_load = 1'b1;
        end else if (deal_req) begin
          deal_valid_d  = 1'b1;
          deal_suit_d   = dec_suit;
          deal_rank_d   = dec_rank;
          deal_points_d = dec_points;
          rd_ptr_d      = rd_ptr_q + PTR_W'(1);
          cards_left_d  = cards_left_q - 6'd1;
          if (cards_left_q == 6'd1) begin
            state_d = ST_EMPTY;
          end
        end
      end

      ST_EMPTY: begin
        if (start) begin
          start_load = 1'b1;
        end else if (deal_req) begin
          empty_err_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_load) begin
      state_d      = ST_LOAD;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      cards_left_d = '0;
      load_err_d   = 1'b0;
`ifdef DEAL_DUP_CHECK_EN
      seen_d       = '0;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cards_left_q  <= '0;
      deal_valid_q  <= 1'b0;
      deal_suit_q   <= '0;
      deal_rank_q   <= '0;
      deal_points_q <= '0;
      load_err_q    <= 1'b0;
      empty_err_q   <= 1'b0;
`ifdef DEAL_DUP_CHECK_EN
      seen_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cards_left_q  <= cards_left_d;
      deal_valid_q  <= deal_valid_d;
      deal_suit_q   <= deal_suit_d;
      deal_rank_q   <= deal_rank_d;
      deal_points_q <= deal_points_d;
      load_err_q    <= load_err_d;
      empty_err_q   <= empty_err_d;
`ifdef DEAL_DUP_CHECK_EN
      seen_q        <= seen_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      deck_mem[wr_ptr_q] <= card_in;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign shuffle_req = (state_q == ST_LOAD);
  assign deck_ready  = (state_q == ST_READY);
  assign low_deck    = (state_q == ST_READY) &&
                       (cards_left_q <= 6'(LOW_THRESH));
  assign cards_left  = cards_left_q;
  assign deal_valid  = deal_valid_q;
  assign deal_rank   = deal_rank_q;
  assign deal_points = deal_points_q;
  assign load_err    = load_err_q;
  assign empty_err   = empty_err_q;

  // Only suit and rank of the last dealt card are held; the card code is
  // rebuilt from them. Rank 0 only occurs before the first deal, where the
  // code must read as 0.
  assign deal_card = (deal_rank_q == 4'd0) ? '0 :
                     CARD_W'(deal_suit_q) * CARD_W'(RANKS_PER_SUIT) +
                     CARD_W'(deal_rank_q) - CARD_W'(1);

endmodule
`default_nettype wire

// File: tb/tb_card_dealer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_card_dealer
//  Description : Self-checking bench for card_dealer. Stimulus pushes the
//                expected dealt cards / empty errors into a scoreboard; a
//                monitor on the falling edge pops and compares whenever the
//                DUT presents deal_valid or empty_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       card_valid = 1'b0;
  logic [5:0] card_in = 6'd0;
  logic       deal_req = 1'b0;
  logic       shuffle_req, deck_ready, deal_valid, low_deck, load_err, empty_err;
  logic [5:0] deal_card, cards_left;
  logic [3:0] deal_rank, deal_points;

  card_dealer #(.LOW_THRESH(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .card_valid  (card_valid),
    .card_in     (card_in),
    .deal_req    (deal_req),
    .shuffle_req (shuffle_req),
    .deck_ready  (deck_ready),
    .deal_valid  (deal_valid),
    .deal_card   (deal_card),
    .deal_rank   (deal_rank),
    .deal_points (deal_points),
    .cards_left  (cards_left),
    .low_deck    (low_deck),
    .load_err    (load_err),
    .empty_err   (empty_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] card;
    logic [3:0] rank;
    logic [3:0] points;
  } deal_t;

  deal_t sb_q[$];
  int    exp_empty = 0;
  int    tests = 0;
  int    fails = 0;

  // Expected decode for a card code: rank = c%13+1, Ace=11, J/Q/K=10.
  function automatic deal_t ref_deal(input int c);
    deal_t d;
    int    r;
    r        = c % 13 + 1;
    d.card   = 6'(c);
    d.rank   = 4'(r);
    d.points = (r == 1) ? 4'd11 : ((r > 10) ? 4'd10 : 4'(r));
    return d;
  endfunction

  function automatic logic [25:0] all_outs();
    return {shuffle_req, deck_ready, deal_valid, deal_card, deal_rank,
            deal_points, cards_left, low_deck, load_err, empty_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_card(input int c);
    card_valid = 1'b1;
    card_in    = 6'(c);
    cyc();
    card_valid = 1'b0;
  endtask

  task automatic push(input int c, input int r, input int p);
    deal_t d;
    d.card   = 6'(c);
    d.rank   = 4'(r);
    d.points = 4'(p);
    sb_q.push_back(d);
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (deal_valid) begin
        deal_t e;
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_deal: got card %0d, required no deal",
                   deal_card);
        end else begin
          e = sb_q.pop_front();
          if ({deal_card, deal_rank, deal_points} !== e) begin
            fails++;
            $display("FAIL deal: got card %0d rank %0d pts %0d, required card %0d rank %0d pts %0d",
                     deal_card, deal_rank, deal_points, e.card, e.rank, e.points);
          end
        end
      end
      if (empty_err) begin
        tests++;
        if (exp_empty == 0) begin
          fails++;
          $display("FAIL unexpected_empty_err: got 1, required 0");
        end else begin
          exp_empty--;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset ----------------
    rst = 1'b0;
    repeat (3) cyc();
    check("reset_outputs", 32'(all_outs()), 0);
    rst = 1'b1;
    cyc();

    // ---------------- load 0..51 ----------------
    send_start();
    check("load_shuffle_req", shuffle_req, 1);
    for (int c = 0; c < 52; c++) begin
      send_card(c);
      if (c < 51) begin
        check("load_shuffle_req_hold", shuffle_req, 1);
        check("load_not_ready", deck_ready, 0);
      end
    end
    check("ready_deck_ready", deck_ready, 1);
    check("ready_cards_left", cards_left, 52);
    check("ready_shuffle_req", shuffle_req, 0);
    check("ready_load_err", load_err, 0);

    // ---------------- held deal of the whole deck ----------------
    deal_req = 1'b1;
    for (int i = 0; i < 52; i++) begin
      sb_q.push_back(ref_deal(i));
      cyc();
      check("held_cards_left", cards_left, 32'(51 - i));
      check("held_low_deck", low_deck, ((51 - i) <= 15 && (51 - i) > 0) ? 1 : 0);
      if (i == 0) begin
        check("ace_rank", deal_rank, 1);
        check("ace_points", deal_points, 11);
      end
      if (i == 9) begin
        check("ten_rank", deal_rank, 10);
        check("ten_points", deal_points, 10);
      end
    end
    check("empty_deck_ready", deck_ready, 0);
    exp_empty++;
    cyc();
    check("empty_no_deal", deal_valid, 0);
    check("empty_err_pulse", empty_err, 1);
    deal_req = 1'b0;
    cyc();
    check("empty_err_one_cycle", empty_err, 0);

    // ---------------- load 51..0, three single deals ----------------
    send_start();
    for (int c = 51; c >= 0; c--) send_card(c);
    check("rev_ready", deck_ready, 1);
    push(51, 13, 10);
    push(50, 12, 10);
    push(49, 11, 10);
    for (int i = 0; i < 3; i++) begin
      deal_req = 1'b1;
      cyc();
      deal_req = 1'b0;
      cyc();
    end
    check("rev_cards_left", cards_left, 49);
    check("hold_card", deal_card, 49);
    check("hold_rank", deal_rank, 11);
    check("hold_points", deal_points, 10);
    check("hold_no_valid", deal_valid, 0);

    // ---------------- start + deal_req together in READY ----------------
    start    = 1'b1;
    deal_req = 1'b1;
    cyc();
    start    = 1'b0;
    deal_req = 1'b0;
    check("collide_no_deal", deal_valid, 0);
    check("collide_shuffle_req", shuffle_req, 1);
    check("collide_cards_left", cards_left, 0);
    check("collide_not_ready", deck_ready, 0);

    // ---------------- out-of-range card during load ----------------
    for (int c = 0; c < 10; c++) send_card(c);
    send_card(60);
    check("bad_card_load_err", load_err, 1);
    check("bad_card_still_loading", shuffle_req, 1);
    for (int c = 10; c < 51; c++) send_card(c);
    check("bad_card_not_ready_early", deck_ready, 0);
    send_card(51);
    check("bad_card_ready", deck_ready, 1);
    check("bad_card_cards_left", cards_left, 52);
    check("bad_card_err_sticky", load_err, 1);
    deal_req = 1'b1;
    for (int i = 0; i < 11; i++) begin
      sb_q.push_back(ref_deal(i));
      cyc();
    end
    deal_req = 1'b0;
    cyc();
    check("bad_card_left_after", cards_left, 41);

    // ---------------- duplicate card during load ----------------
    send_start();
    check("dup_err_cleared", load_err, 0);
    for (int c = 0; c < 8; c++) send_card(c);
    send_card(7);
    for (int c = 8; c < 51; c++) send_card(c);
`ifdef DEAL_DUP_CHECK_EN
    check("dup_not_ready", deck_ready, 0);
    check("dup_load_err", load_err, 1);
    send_card(51);
    check("dup_ready", deck_ready, 1);
    check("dup_cards_left", cards_left, 52);
    for (int i = 0; i < 10; i++) sb_q.push_back(ref_deal(i));
`else
    check("dup_ready", deck_ready, 1);
    check("dup_load_err", load_err, 0);
    check("dup_cards_left", cards_left, 52);
    for (int i = 0; i < 8; i++) sb_q.push_back(ref_deal(i));
    sb_q.push_back(ref_deal(7));
    sb_q.push_back(ref_deal(8));
`endif
    deal_req = 1'b1;
    repeat (10) cyc();
    deal_req = 1'b0;
    cyc();
    check("dup_left_after", cards_left, 42);

    // ---------------- reset mid-load ----------------
    send_start();
    for (int c = 0; c < 20; c++) send_card(c);
    rst = 1'b0;
    #2;
    check("midload_reset_outputs", 32'(all_outs()), 0);
    cyc();
    rst = 1'b1;
    cyc();
    check("post_reset_idle", shuffle_req, 0);
    send_start();
    for (int c = 0; c < 51; c++) send_card(c);
    check("post_reset_full_load_needed", deck_ready, 0);
    send_card(51);
    check("post_reset_ready", deck_ready, 1);
    check("post_reset_cards_left", cards_left, 52);
    sb_q.push_back(ref_deal(0));
    deal_req = 1'b1;
    cyc();
    deal_req = 1'b0;
    repeat (3) cyc();

    check("scoreboard_drained", sb_q.size(), 0);
    check("empty_err_drained", exp_empty, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Downstream stage of the deck shuffler.
- Requests a shuffle, captures the 52-card stream into a local deck buffer, then serves one card per deal request to the game controller.
- Decodes each dealt card into rank and blackjack points.
- Tracks remaining cards and raises a low-deck flag so the controller can trigger a reshuffle.

Parameters:
- DECK_SIZE, 52, number of cards captured per shuffle.
- CARD_W, 6, card code width.
- LOW_THRESH, 15, low_deck asserts when cards_left <= LOW_THRESH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- start  in  1  one-cycle pulse: begin a new shuffle/load.
- card_valid  in  1  one-cycle strobe per card from the shuffler.
- card_in  in  CARD_W  card code 0..51, valid with card_valid.
- deal_req  in  1  request one card; may be held high for back-to-back deals.
- shuffle_req  out  1  drives the shuffler's shuffleFlag.
- deck_ready  out  1  deck loaded and not empty.
- deal_valid  out  1  one-cycle strobe, dealt card outputs valid.
- deal_card  out  CARD_W  dealt card code.
- deal_rank  out  4  1=Ace..13=King.
- deal_points  out  4  Ace=11, 2..10 face value, J/Q/K=10.
- cards_left  out  6  undealt cards remaining.
- low_deck  out  1  cards_left <= LOW_THRESH while in READY.
- load_err  out  1  sticky; set on an invalid or duplicate card; cleared by start.
- empty_err  out  1  one-cycle pulse: deal_req with no cards left.

Behaviour:
- Reset (rst=0, async): state IDLE, wr_ptr=rd_ptr=0, every output 0. Buffer contents don't care.
- State IDLE: start -> LOAD.
- State LOAD:
  - shuffle_req=1; load_err cleared on entry.
  - Each card_valid with card_in<52 writes buffer[wr_ptr] and increments wr_ptr.
  - card_in>=52 is discarded and sets load_err.
  - When the DECK_SIZE-th card is written: next cycle state=READY, shuffle_req=0, deck_ready=1, cards_left=DECK_SIZE, rd_ptr=0.
  - start and deal_req are ignored in LOAD.
- State READY:
  - deal_req sampled at cycle N -> at N+1: deal_valid=1, deal_card=buffer[rd_ptr], decoded rank/points; rd_ptr and cards_left update at the same edge.
  - A held deal_req deals one card every cycle.
  - deal_card/deal_rank/deal_points hold their last values while deal_valid=0.
- Empty deck:
  - The deal that brings cards_left to 0 -> state EMPTY, deck_ready=0.
  - deal_req in EMPTY -> empty_err pulse next cycle, deal_valid stays 0.
  - start in EMPTY -> LOAD.
- Start in READY (mid-deck reshuffle): remaining cards discarded, wr_ptr=rd_ptr=0, state LOAD.
- Simultaneous start and deal_req in READY: start wins, no card dealt.
- card_valid outside LOAD is ignored.
- Decode: suit = card/13 (unused externally); rank = card%13 + 1.
- Reset asserted mid-operation aborts immediately to IDLE.

Optional Feature:
- Macro: DEAL_DUP_CHECK_EN.
- Defined: a DECK_SIZE-bit seen vector, cleared on entry to LOAD. A card already seen is discarded, not counted, and sets load_err; load completes only after DECK_SIZE unique cards.
- Undefined: no duplicate check; every in-range card is stored.

Decomposition:
- Shared package/include card_pkg:
  - constants DECK_SIZE, CARD_W, RANKS_PER_SUIT=13, ACE_POINTS=11, FACE_POINTS=10;
  - state encoding IDLE/LOAD/READY/EMPTY.
- One natural combinational sub-module, card_decode: card code -> rank, points, suit. Shared with the hand-scoring logic.

Test Plan:
- Reset, then start, then 52 strobes of cards 0..51 -> shuffle_req 1 throughout load; deck_ready=1 and cards_left=52 one cycle after the last strobe.
- Load order 51..0, then 3 single deal_req -> cards 51,50,49 with points 10,10,10 (rank 13,12,11); cards_left=49.
- deal_req held for 52 cycles -> 52 consecutive deal_valid pulses. Card 0 reports rank 1, points 11; card 9 reports rank 10, points 10. low_deck rises when cards_left reaches 15; state EMPTY after the last deal; the 53rd request gives an empty_err pulse and no deal_valid.
- card_in=60 during load -> load_err=1, wr_ptr unchanged; load finishes after 52 valid cards. With DEAL_DUP_CHECK_EN, card 7 sent twice -> second discarded, load_err=1, 53 strobes needed.
- start and deal_req in the same cycle in READY -> no deal_valid; shuffle_req=1 next cycle; cards_left=0.
- rst pulsed low mid-load after 20 cards -> all outputs 0 immediately; a subsequent start needs a full 52 cards.
